traffic_gen: RTL and testbench

TRAFFIC_GEN -- requirements
Module: traffic_gen

---
 rtl/traffic_gen.sv | 125 ++++++++++++
 tb/tb_traffic_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_gen.sv
// NoC traffic generator: builds packets with REVERSE, NEIGHBOR or UNIFORM (LFSR) destinations,
// and holds a packet on o_data until the NoC accepts it. Stops at PKT_LIMIT accepted packets.
module traffic_gen #(
    parameter int          ADDRESS    = 0,
    parameter int          NUM_PE     = 16,
    parameter int          ADDR_WIDTH = 4,   // log2(NUM_PE), at most 16
    parameter int          DATA_WIDTH = 32,
    parameter int          PKT_LIMIT  = 100,
    parameter int          PATTERN    = 0,   // 0=REVERSE, 1=NEIGHBOR, 2=UNIFORM
    parameter int          GAP        = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                             clk100,
    input  logic                             rst,
    input  logic                             i_enable,
    output logic [DATA_WIDTH+ADDR_WIDTH-1:0] o_data,
    output logic                             o_data_valid,
    input  logic                             i_data_ready,
    output logic [31:0]                      o_sent_count,
    output logic                             o_done
);
    localparam int TW = DATA_WIDTH - ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] SRC      = ADDR_WIDTH'(ADDRESS);
    localparam logic [ADDR_WIDTH-1:0] DEST_REV = ADDR_WIDTH'(NUM_PE - 1 - ADDRESS);
    localparam logic [ADDR_WIDTH-1:0] DEST_NB  = ADDR_WIDTH'((ADDRESS + 1) % NUM_PE);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_GAP, DONE} state_t;

    state_t                           state_q, state_d;
    logic [TW-1:0]                    ts_q, ts_d;
    logic [15:0]                      lfsr_q, lfsr_d;
    logic [31:0]                      cnt_q, cnt_d;
    logic [31:0]                      gap_q, gap_d;
    logic [DATA_WIDTH+ADDR_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0]            dest;
    logic                             xfer;
    logic                             load;

    assign xfer = (state_q == SEND) && i_data_ready;
    assign ts_d = ts_q + TW'(1);

    // A back-to-back reload must see the LFSR value already advanced by this transfer.
    always_comb begin
        lfsr_d = lfsr_q;
        if (xfer) begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    always_comb begin
        dest = DEST_REV;
        case (PATTERN)
            0:       dest = DEST_REV;
            1:       dest = DEST_NB;
            default: dest = (lfsr_d[ADDR_WIDTH-1:0] == SRC) ? DEST_NB : lfsr_d[ADDR_WIDTH-1:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (PKT_LIMIT == 0) begin
                    state_d = DONE;
                end else if (i_enable) begin
                    state_d = SEND;
                    load    = 1'b1;
                end
            end
            SEND: begin
                if (i_data_ready) begin
                    cnt_d = cnt_q + 32'd1;
                    if (cnt_d == 32'(PKT_LIMIT)) begin
                        state_d = DONE;
                    end else if (GAP == 0) begin
                        state_d = i_enable ? SEND : IDLE;
                        load    = i_enable;
                    end else begin
                        state_d = WAIT_GAP;
                        gap_d   = 32'(GAP - 1);
                    end
                end
            end
            WAIT_GAP: begin
                if (gap_q == 32'd0) begin
                    state_d = i_enable ? SEND : IDLE;
                    load    = i_enable;
                end else begin
                    gap_d = gap_q - 32'd1;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // The timestamp is the counter value visible during the first SEND cycle.
    assign data_d = load ? {dest, SRC, ts_d} : data_q;

    always_ff @(posedge clk100) begin
        if (rst) begin
            state_q <= IDLE;
            ts_q    <= '0;
            lfsr_q  <= LFSR_SEED;
            cnt_q   <= '0;
            gap_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
        end
    end

    assign o_data       = data_q;
    assign o_data_valid = (state_q == SEND);
    assign o_done       = (state_q == DONE);
    assign o_sent_count = cnt_q;
endmodule

// File: tb/tb_traffic_gen.sv
// Three generator instances (UNIFORM random handshake with mid-send reset, REVERSE burst,
// NEIGHBOR with gaps) checked against a packet-sequence scoreboard.
module tb_traffic_gen;
    localparam int NPE = 16;
    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int TW  = DW - AW;

    logic clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s [inst %0d]: got 0x%0h, expected 0x%0h", name, g, act, exp);
        end
    endtask

    // Polynomial x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci register.
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic fb;
        fb = 1'b0;
        foreach (l[i]) if (i == 16 - 16 || i == 16 - 14 || i == 16 - 13 || i == 16 - 11) fb ^= l[i];
        return {fb, l[15:1]};
    endfunction

    function automatic logic [AW-1:0] model_dest(input int pat, input int addr, input logic [15:0] l);
        int r;
        if (pat == 0) return AW'(NPE - 1 - addr);
        if (pat == 1) return AW'((addr + 1) % NPE);
        r = int'(l) % NPE;
        if (r == addr) r = (addr + 1) % NPE;
        return AW'(r);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int ADDR = (g == 0) ? 1 : (g == 1) ? 3 : 15;
        localparam int PAT  = (g == 0) ? 2 : (g == 1) ? 0 : 1;
        localparam int GP   = (g == 2) ? 3 : 0;
        localparam int LIM  = (g == 0) ? 200 : (g == 1) ? 4 : 6;

        logic          rst_s = 1'b1;
        logic          en_s  = 1'b0;
        logic          rdy_s = 1'b0;
        logic [DW+AW-1:0] dat;
        logic          vld;
        logic [31:0]   cnt;
        logic          done;
        bit            fin   = 1'b0;
        logic [15:0]   seen  = '0;

        traffic_gen #(
            .ADDRESS(ADDR), .NUM_PE(NPE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
            .PKT_LIMIT(LIM), .PATTERN(PAT), .GAP(GP), .LFSR_SEED(16'hACE1)
        ) dut (
            .clk100(clk100), .rst(rst_s), .i_enable(en_s), .o_data(dat),
            .o_data_valid(vld), .i_data_ready(rdy_s), .o_sent_count(cnt), .o_done(done)
        );

        // Monitor: outputs at negedge reflect the previous edge; inputs seen here feed the next edge.
        initial begin : mon
            logic [AW-1:0] dq[$];
            logic [15:0]   l;
            logic [AW-1:0] d;
            logic [TW-1:0] cyc;
            logic [DW+AW-1:0] held_dat;
            bit pr_rst, held, exp_vld, nv;
            int exp_cnt, forbid;
            pr_rst = 1'b1; held = 1'b0; exp_vld = 1'b0; exp_cnt = 0; forbid = 0;
            cyc = '0; held_dat = '0;
            forever begin
                @(negedge clk100);
                if (pr_rst) begin
                    cyc = '0; exp_cnt = 0; held = 1'b0; forbid = 0; exp_vld = 1'b0;
                    dq.delete();
                    l = 16'hACE1;
                    for (int k = 0; k < LIM; k++) begin
                        dq.push_back(model_dest(PAT, ADDR, l));
                        l = lfsr_next(l);
                    end
                    check("reset_data", g, 64'(dat), 64'd0);
                end else begin
                    cyc = cyc + TW'(1);
                end
                check("valid", g, 64'(vld), 64'(exp_vld));
                check("sent_count", g, 64'(cnt), 64'(exp_cnt));
                check("done", g, 64'(done), 64'(exp_cnt == LIM));
                if (vld && exp_vld) begin
                    if (held) begin
                        check("stall_stable", g, 64'(dat), 64'(held_dat));
                    end else if (dq.size() == 0) begin
                        check("unexpected_packet", g, 64'(dat), 64'd0);
                    end else begin
                        d = dq.pop_front();
                        check("dest", g, 64'(dat[DW+AW-1:DW]), 64'(d));
                        check("src", g, 64'(dat[DW-1:TW]), 64'(ADDR));
                        check("timestamp", g, 64'(dat[TW-1:0]), 64'(cyc));
                        seen[dat[DW+AW-1:DW]] = 1'b1;
                        held_dat = dat;
                    end
                end
                pr_rst = rst_s;
                if (!rst_s) begin
                    if (exp_vld && rdy_s) begin
                        exp_cnt++;
                        held   = 1'b0;
                        forbid = GP;
                        nv = (exp_cnt < LIM) && (GP == 0) && en_s;
                    end else if (exp_vld) begin
                        held = 1'b1;
                        nv   = 1'b1;
                    end else if (exp_cnt == LIM) begin
                        nv = 1'b0;
                    end else if (forbid > 0) begin
                        forbid--;
                        nv = (forbid == 0) && en_s;
                    end else begin
                        nv = en_s;
                    end
                    exp_vld = nv;
                end
            end
        end

        initial begin : stim
            repeat (3) @(posedge clk100);
            #1 rst_s = 1'b0;
            en_s = 1'b1;
            if (g == 0) begin
                // Random ready until two packets are out, then reset while a packet is stalled.
                for (int i = 0; i < 300; i++) begin
                    rdy_s = 1'($urandom_range(0, 1));
                    if (cnt >= 2 && vld) begin
                        rdy_s = 1'b0;
                        rst_s = 1'b1;
                    end
                    @(posedge clk100); #1;
                    if (rst_s) break;
                end
                check("reset_setup_reached", g, 64'(rst_s), 64'd1);
                rst_s = 1'b0;
                rdy_s = 1'b0;
                for (int i = 0; i < 50 && !vld; i++) begin
                    @(posedge clk100); #1;
                end
                repeat (5) @(posedge clk100);
                #1 rdy_s = 1'b1;
                for (int i = 0; i < 4000 && !done; i++) begin
                    en_s  = ($urandom_range(0, 3) != 0);
                    rdy_s = ($urandom_range(0, 4) < 3);
                    @(posedge clk100); #1;
                end
                check("uniform_reaches_done", g, 64'(done), 64'd1);
            end else begin
                rdy_s = 1'b1;
                repeat (40) @(posedge clk100);
                #1;
            end
            for (int i = 0; i < 10; i++) begin
                en_s  = 1'($urandom_range(0, 1));
                rdy_s = 1'($urandom_range(0, 1));
                @(posedge clk100); #1;
            end
            fin = 1'b1;
        end
    end

    initial begin
        bit all_fin;
        all_fin = 1'b0;
        for (int i = 0; i < 20000 && !all_fin; i++) begin
            @(posedge clk100);
            all_fin = g_inst[0].fin && g_inst[1].fin && g_inst[2].fin;
        end
        check("run_completes", 0, 64'(all_fin), 64'd1);
        @(negedge clk100);
        check("uniform_dest_coverage", 0, 64'(g_inst[0].seen), 64'hFFFD);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
